// File: rtl/adders_pkg.sv
// Shared constants for the nibble-serial adder: nibble width, controller
// state encodings and the index-width helper.
package adders_pkg;

  localparam int NIBBLE_W = 4;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_ADD  = 2'd1;
  localparam state_t ST_DONE = 2'd2;

  // A single-nibble configuration still needs a one-bit index register.
  function automatic int idx_w(input int nibbles);
    return (nibbles > 1) ? $clog2(nibbles) : 1;
  endfunction

endpackage

// File: rtl/ripple_adder_4bit.sv
// One 4-bit ripple-carry adder; the shared nibble datapath of the serial adder.
module ripple_adder_4bit (
  output logic [3:0] Sum,
  output logic       Cout,
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       Cin
);

  logic c1, c2, c3;

  assign Sum[0] = A[0] ^ B[0] ^ Cin;
  assign c1     = (A[0] & B[0]) | (Cin & (A[0] ^ B[0]));
  assign Sum[1] = A[1] ^ B[1] ^ c1;
  assign c2     = (A[1] & B[1]) | (c1 & (A[1] ^ B[1]));
  assign Sum[2] = A[2] ^ B[2] ^ c2;
  assign c3     = (A[2] & B[2]) | (c2 & (A[2] ^ B[2]));
  assign Sum[3] = A[3] ^ B[3] ^ c3;
  assign Cout   = (A[3] & B[3]) | (c3 & (A[3] ^ B[3]));

endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// Serial add/subtract controller: one nibble per clock through a shared 4-bit
// ripple adder, LS nibble first, with valid/ready start and result handshakes.
module nibble_serial_adder_ctrl
  import adders_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start_valid,
  output logic                      start_ready,
  input  logic [NIBBLE_W*NIBBLES-1:0] a,
  input  logic [NIBBLE_W*NIBBLES-1:0] b,
  input  logic                      cin,
  input  logic                      sub,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic [NIBBLE_W*NIBBLES-1:0] sum,
  output logic                      cout,
  output logic                      ovf,
  output logic                      busy
);

  localparam int W     = NIBBLE_W * NIBBLES;
  localparam int IDX_W = idx_w(NIBBLES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  state_t              state;
  logic [W-1:0]        a_reg;
  logic [W-1:0]        b_reg;
  logic                carry_reg;
  logic [IDX_W-1:0]    idx;
  logic [NIBBLE_W-1:0] a_nib;
  logic [NIBBLE_W-1:0] b_nib;
  logic [NIBBLE_W-1:0] add_sum;
  logic                add_cout;

  assign start_ready = (state == ST_IDLE);
  assign res_valid   = (state == ST_DONE);
  assign busy        = (state != ST_IDLE);

  assign a_nib = a_reg[idx*NIBBLE_W +: NIBBLE_W];
  assign b_nib = b_reg[idx*NIBBLE_W +: NIBBLE_W];

  ripple_adder_4bit u_adder (
    .Sum  (add_sum),
    .Cout (add_cout),
    .A    (a_nib),
    .B    (b_nib),
    .Cin  (carry_reg)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      carry_reg <= 1'b0;
      idx       <= '0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_valid) begin
            // Subtract is a + ~b + 1, so the inverted operand and forced carry are captured here.
            a_reg     <= a;
            b_reg     <= sub ? ~b : b;
            carry_reg <= sub ? 1'b1 : cin;
            idx       <= '0;
            sum       <= '0;
            state     <= ST_ADD;
          end
        end
        ST_ADD: begin
          sum[idx*NIBBLE_W +: NIBBLE_W] <= add_sum;
          carry_reg <= add_cout;
          if (idx == LAST_IDX) begin
            idx   <= '0;
            cout  <= add_cout;
            ovf   <= (a_reg[W-1] == b_reg[W-1]) && (add_sum[NIBBLE_W-1] != a_reg[W-1]);
            state <= ST_DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        ST_DONE: begin
          if (res_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Randomized and directed bench for nibble_serial_adder_ctrl with a
// transaction-level arithmetic model and per-cycle output comparison.
module tb_nibble_serial_adder_ctrl;

  localparam int N = 4;
  localparam int W = 4 * N;

  logic         clk;
  logic         rst;
  logic         start_valid;
  logic         start_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         sub;
  logic         res_valid;
  logic         res_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;
  logic         busy;

  int checks = 0;
  int errors = 0;

  nibble_serial_adder_ctrl #(.NIBBLES(N)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .a           (a),
    .b           (b),
    .cin         (cin),
    .sub         (sub),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .sum         (sum),
    .cout        (cout),
    .ovf         (ovf),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: mode 0 = idle, 1 = computing, 2 = result offered.
  int           m_mode;
  int           m_left;
  logic [W-1:0] m_sum;
  logic         m_cout;
  logic         m_ovf;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_mode = 0;
      m_left = 0;
      m_sum  = '0;
      m_cout = 1'b0;
      m_ovf  = 1'b0;
    end else begin
      case (m_mode)
        0: if (start_valid) begin
          longint ua, ub, full;
          longint sa, sb, sres;
          ua = longint'(a);
          ub = longint'(b);
          sa = longint'($signed(a));
          sb = longint'($signed(b));
          if (sub) begin
            full   = ua - ub;
            sres   = sa - sb;
            m_cout = (ua >= ub);
          end else begin
            full   = ua + ub + longint'(cin);
            sres   = sa + sb + longint'(cin);
            m_cout = full >= (longint'(1) << W);
          end
          m_sum  = W'(full);
          m_ovf  = (sres > 32767) || (sres < -32768);
          m_left = N;
          m_mode = 1;
        end
        1: begin
          m_left--;
          if (m_left == 0) m_mode = 2;
        end
        default: if (res_ready) m_mode = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("start_ready", 32'(start_ready), 32'(m_mode == 0));
      chk("res_valid", 32'(res_valid), 32'(m_mode == 2));
      chk("busy", 32'(busy), 32'(m_mode != 0));
      if (m_mode != 1) begin
        chk("sum", 32'(sum), 32'(m_sum));
        chk("cout", 32'(cout), 32'(m_cout));
        chk("ovf", 32'(ovf), 32'(m_ovf));
      end
    end
  end

  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_op, input logic tcin,
                        input logic tsub, input int hold, input bit pulse, input bit lit,
                        input logic [W-1:0] es, input logic ec, input logic eo);
    int cyc;
    a           = ta;
    b           = tb_op;
    cin         = tcin;
    sub         = tsub;
    start_valid = 1'b1;
    @(posedge clk);
    #1 start_valid = 1'b0;
    cyc = 0;
    while (!res_valid && cyc < 50) begin
      if (pulse && cyc == 1) begin
        start_valid = 1'b1;
        a = W'($urandom);
        b = W'($urandom);
      end else begin
        start_valid = 1'b0;
      end
      @(posedge clk);
      #1 cyc++;
    end
    start_valid = 1'b0;
    chk("latency", 32'(cyc), 32'(N));
    if (lit) begin
      chk("lit_sum", 32'(sum), 32'(es));
      chk("lit_cout", 32'(cout), 32'(ec));
      chk("lit_ovf", 32'(ovf), 32'(eo));
    end
    repeat (hold) begin
      @(posedge clk);
      #1;
      if (lit) begin
        chk("hold_sum", 32'(sum), 32'(es));
        chk("hold_start_ready", 32'(start_ready), 32'(0));
      end
    end
    res_ready = 1'b1;
    @(posedge clk);
    #1 res_ready = 1'b0;
  endtask

  initial begin
    rst         = 1'b1;
    start_valid = 1'b0;
    a           = '0;
    b           = '0;
    cin         = 1'b0;
    sub         = 1'b0;
    res_ready   = 1'b0;
    #2;
    chk("rst_start_ready", 32'(start_ready), 32'(1));
    chk("rst_res_valid", 32'(res_valid), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_sum", 32'(sum), 32'(0));
    #10 rst = 1'b0;
    @(posedge clk);
    #1;

    run_op(16'h1234, 16'h0FFF, 1'b0, 1'b0, 0, 1'b0, 1'b1, 16'h2233, 1'b0, 1'b0);
    run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0);
    run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b1);
    run_op(16'h8000, 16'h8000, 1'b0, 1'b0, 0, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b1);
    run_op(16'h0005, 16'h0007, 1'b1, 1'b1, 0, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    run_op(16'h0007, 16'h0005, 1'b0, 1'b1, 0, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0);
    run_op(16'h1234, 16'h0FFF, 1'b0, 1'b0, 5, 1'b1, 1'b1, 16'h2233, 1'b0, 1'b0);

    // Reset in the second ADD cycle discards the partial result.
    a           = 16'h1111;
    b           = 16'h2222;
    cin         = 1'b0;
    sub         = 1'b0;
    start_valid = 1'b1;
    @(posedge clk);
    #1 start_valid = 1'b0;
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("midrst_start_ready", 32'(start_ready), 32'(1));
    chk("midrst_res_valid", 32'(res_valid), 32'(0));
    chk("midrst_busy", 32'(busy), 32'(0));
    chk("midrst_sum", 32'(sum), 32'(0));
    chk("midrst_cout", 32'(cout), 32'(0));
    chk("midrst_ovf", 32'(ovf), 32'(0));
    @(posedge clk);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
    run_op(16'h0001, 16'h0001, 1'b0, 1'b0, 0, 1'b0, 1'b1, 16'h0002, 1'b0, 1'b0);

    for (int i = 0; i < 150; i++) begin
      run_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom),
             int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)), 1'b0,
             '0, 1'b0, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/nibble_serial_adder_ctrl.md
# nibble_serial_adder_ctrl

Sequencing controller that performs a parameterisable-width add or subtract by time-multiplexing one 4-bit ripple-carry adder, one nibble per clock, least-significant nibble first. Carry is registered between nibbles. A valid/ready start handshake accepts operands, and a valid/ready result handshake returns sum and flags. The block sits between a requester (ALU sequencer or testbench driver) and the shared 4-bit adder datapath.

## Interface
- NIBBLES, default 4: operand width in nibbles (W = 4*NIBBLES); legal range 1..16.
- clk  in  1: single clock, rising edge.
- rst  in  1: asynchronous, active-high reset.
- start_valid  in  1: requester presents operands.
- start_ready  out  1: high only in IDLE.
- a  in  W: operand A, sampled on start acceptance.
- b  in  W: operand B, sampled on start acceptance.
- cin  in  1: carry-in, sampled on acceptance; ignored when sub=1.
- sub  in  1: 1 = compute a - b (two's complement), sampled on acceptance.
- res_valid  out  1: sum, cout and ovf are valid.
- res_ready  in  1: consumer accepts the result.
- sum  out  W: result.
- cout  out  1: final carry-out; for sub, 1 = no borrow.
- ovf  out  1: signed two's-complement overflow.
- busy  out  1: high in ADD or DONE.

## Operation
- FSM states are IDLE, ADD and DONE.
- IDLE → ADD on start_valid && start_ready. On that edge:
  - latch a, b_eff = sub ? ~b : b, and sub;
  - carry_reg = sub ? 1 : cin;
  - idx = 0; clear the sum register.
- ADD, each cycle: the adder takes a[idx], b_eff[idx], carry_reg. On the edge:
  - sum nibble idx is written;
  - carry_reg = adder Cout;
  - idx increments.
- ADD → DONE on the edge where idx == NIBBLES-1.
- On the ADD → DONE edge:
  - cout = adder Cout;
  - ovf = (a[W-1] == b_eff[W-1]) && (sum[W-1] != a[W-1]).
- DONE → IDLE on res_valid && res_ready. sum, cout and ovf then keep their values until the next acceptance.
- start_valid outside IDLE is ignored. No start is accepted in the same cycle as the result handshake.
- Arithmetic is modulo 2^W. No width extension; cout is the only carry beyond bit W-1.
- NIBBLES=1 degenerates to one ADD cycle.

## Timing
- Reset values: state=IDLE, start_ready=1, res_valid=0, busy=0, sum=0, cout=0, ovf=0; internal idx=0, carry_reg=0.
- Latency: acceptance at edge E0 gives res_valid high after edge E0+NIBBLES, i.e. NIBBLES cycles later.
- Throughput: minimum NIBBLES+2 cycles per operation (ADD×N, DONE×1, IDLE×1).
- res_valid rises only at DONE entry. While res_ready=0, sum/cout/ovf are held stable indefinitely.
- start_ready and res_valid are registered-state decodes. There is no combinational path from start_valid or res_ready to any output.
- Reset asserted mid-ADD or mid-DONE returns everything to reset values immediately. The partial result is discarded.
- Adder path: one 4-bit ripple per cycle. The critical path is carry_reg → 4-bit ripple → carry_reg.

## Structure
- The shared package adders_pkg holds:
  - NIBBLE_W = 4;
  - the state typedef/localparams ST_IDLE, ST_ADD, ST_DONE;
  - the IDX_W width function clog2(NIBBLES).
- One sub-module is instantiated: ripple_adder_4bit (Sum, Cout, A, B, Cin) as the nibble datapath.
- Nibble select and write-back use idx-indexed part-selects in the controller.

## Test plan
All cases use NIBBLES=4.
- a=0x1234, b=0x0FFF, cin=0, sub=0 → sum=0x2233, cout=0, ovf=0; res_valid exactly 4 cycles after acceptance.
- a=0xFFFF, b=0x0001, cin=0 → sum=0x0000, cout=1, ovf=0. Carry ripples across all nibble boundaries.
- a=0x7FFF, b=0x0001 → sum=0x8000, ovf=1, cout=0. Then a=0x8000, b=0x8000 → sum=0x0000, ovf=1, cout=1.
- sub=1, a=0x0005, b=0x0007, cin=1 (ignored) → sum=0xFFFE, cout=0, ovf=0. Then a=0x0007, b=0x0005 → 0x0002, cout=1.
- Hold res_ready=0 for 5 cycles in DONE → outputs stable and start_ready=0 throughout. Pulse start_valid during ADD → not accepted, result unchanged.
- Assert rst during the 2nd ADD cycle → all outputs at reset values asynchronously, start_ready=1. A fresh 0x0001+0x0001 then yields 0x0002.
